// File: rtl/riscv_pkg.sv
// Shared UART constants and transmitter/receiver state encoding.
package riscv_pkg;

    localparam int UART_CLKS_PER_BIT = 868;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; status is derived purely from pointer state.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Same index with differing wrap bits means the ring is completely full.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign level = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small write FIFO so CPU store bursts never stall.
module uart_tx_fifo
    import riscv_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    input  logic                          clr_overflow,
    output logic                          full,
    output logic                          empty,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          tx
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    uart_state_t  state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]   bit_idx;
    logic [7:0]   shift;
    logic [7:0]   head;
    logic         baud_last;
    logic         pop;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_en),
        .wdata (wr_data),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign baud_last = (baud_cnt == CW'(CLKS_PER_BIT - 1));
    // Pop in IDLE, or on the final stop-bit cycle so frames run back-to-back.
    assign pop = !empty && ((state == IDLE) || ((state == STOP) && baud_last));
    assign busy = (state != IDLE) || !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    tx       <= 1'b1;
                    if (pop) begin
                        shift <= head;
                        state <= START;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        tx       <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift <= head;
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    baud_cnt <= '0;
                    tx       <= 1'b1;
                end
            endcase
        end
    end

    // A write that hits a full FIFO takes priority over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overflow <= 1'b0;
        else if (wr_en && full)
            overflow <= 1'b1;
        else if (clr_overflow)
            overflow <= 1'b0;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized scoreboard bench: frame-level reference model vs. serial decoder and status checks.
module tb_uart_tx_fifo;
    localparam int C     = 4;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_overflow;
    logic       full, empty, busy, overflow, tx;
    logic [3:0] level;

    uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .clr_overflow (clr_overflow),
        .full         (full),
        .empty        (empty),
        .busy         (busy),
        .level        (level),
        .overflow     (overflow),
        .tx           (tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic tx;
        int   level;
        logic ovf;
        logic busy;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] sb_q[$];
    int         total = 0;
    int         bad   = 0;
    logic       done  = 1'b0;

    // Reference model: byte queue plus "cycles left in the current frame".
    initial begin
        logic [7:0] mq[$];
        logic [7:0] cur;
        int   rem;
        int   pre;
        int   k;
        int   b;
        logic movf;
        exp_t e;
        rem = 0; movf = 1'b0; cur = 8'h00;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                mq.delete();
                sb_q.delete();
                rem  = 0;
                movf = 1'b0;
            end else begin
                pre = mq.size();
                if (rem > 0) rem--;
                if (rem == 0 && pre > 0) begin
                    cur = mq.pop_front();
                    rem = 10 * C;
                end
                if (wr_en && pre < DEPTH) begin
                    mq.push_back(wr_data);
                    sb_q.push_back(wr_data);
                end
                if (wr_en && pre == DEPTH) movf = 1'b1;
                else if (clr_overflow)     movf = 1'b0;
                if (rem == 0) begin
                    e.tx = 1'b1;
                end else begin
                    k = 10 * C - rem;
                    b = k / C;
                    if (b == 0)      e.tx = 1'b0;
                    else if (b <= 8) e.tx = cur[b-1];
                    else             e.tx = 1'b1;
                end
                e.level = mq.size();
                e.ovf   = movf;
                e.busy  = (rem > 0) || (mq.size() > 0);
                exp_q.push_back(e);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Monitor: status compare each cycle and serial frame decode against the scoreboard.
    initial begin
        exp_t       e;
        logic       mon_act;
        int         mon_cnt;
        int         bi;
        logic [7:0] mon_byte;
        mon_act = 1'b0; mon_cnt = 0; mon_byte = 8'h00;
        forever begin
            @(negedge clk);
            if (done) begin
                chk("frames_outstanding", sb_q.size(), 0);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
            if (!rst_n) begin
                exp_q.delete();
                mon_act = 1'b0;
                chk("rst_tx", int'(tx), 1);
                chk("rst_level", int'(level), 0);
                chk("rst_full", int'(full), 0);
                chk("rst_empty", int'(empty), 1);
                chk("rst_busy", int'(busy), 0);
                chk("rst_overflow", int'(overflow), 0);
            end else begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("tx", int'(tx), int'(e.tx));
                    chk("level", int'(level), e.level);
                    chk("full", int'(full), int'(e.level == DEPTH));
                    chk("empty", int'(empty), int'(e.level == 0));
                    chk("busy", int'(busy), int'(e.busy));
                    chk("overflow", int'(overflow), int'(e.ovf));
                end
                if (!mon_act) begin
                    if (tx == 1'b0) begin
                        mon_act = 1'b1;
                        mon_cnt = 0;
                    end
                end else begin
                    mon_cnt++;
                    bi = mon_cnt / C;
                    if ((mon_cnt % C) == C / 2 && bi >= 1 && bi <= 8)
                        mon_byte[bi-1] = tx;
                    if (mon_cnt == 9 * C + C / 2) begin
                        chk("stop_bit", int'(tx), 1);
                        chk("frame_has_expected", int'(sb_q.size() > 0), 1);
                        if (sb_q.size() > 0)
                            chk("rx_byte", int'(mon_byte), int'(sb_q.pop_front()));
                        mon_act = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: no finish, total=%0d", total);
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic clr();
        clr_overflow = 1'b1;
        @(posedge clk);
        #1;
        clr_overflow = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; clr_overflow = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        wr(8'h55);
        idle(50);

        wr(8'h41); wr(8'h42); wr(8'h43);
        idle(130);

        for (int i = 0; i < 9; i++) wr(8'($urandom));
        idle(10 * C * 9 + 10);

        for (int i = 0; i < 10; i++) wr(8'($urandom));
        idle(5);
        clr();
        idle(10 * C * 9 + 10);

        // Fill the FIFO behind one in-flight frame, then write on the stop-bit pop edge.
        for (int i = 0; i < 9; i++) wr(8'($urandom));
        idle(32);
        wr(8'hEE);
        idle(10 * C * 9 + 10);
        clr();
        idle(3);

        // Reset during data bit 3.
        wr(8'hC3);
        idle(17);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        wr(8'hA5);
        idle(50);

        for (int i = 0; i < 20; i++) begin
            wr(8'($urandom));
            idle($urandom_range(30, 50));
        end
        idle(100);

        for (int i = 0; i < 40; i++) begin
            wr_en        = 1'($urandom_range(0, 1));
            wr_data      = 8'($urandom);
            clr_overflow = ($urandom_range(0, 7) == 0);
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0; clr_overflow = 1'b0;
        idle(10 * C * 9 + 20);

        done = 1'b1;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte-wide UART transmitter with a small write FIFO, sitting directly downstream of the DataMemory MMIO decode and driving the board-level `uart_tx_wire` pin. Software stores bytes to the UART data register; DataMemory forwards each store as a one-cycle write strobe and reads back status for polling. The block produces 8N1 frames at a fixed baud set by a cycle-count parameter, so a CPU burst never has to stall on the serial line.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per serial bit (100 MHz / 115200); legal range ≥ 2.
- `FIFO_DEPTH`, 8, byte entries; power of two, ≥ 2.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `wr_en`  in  1  one-cycle store strobe from MMIO decode.
- `wr_data`  in  8  byte to enqueue (low byte of store data).
- `clr_overflow`  in  1  one-cycle strobe; clears `overflow`.
- `full`  out  1  FIFO holds `FIFO_DEPTH` bytes.
- `empty`  out  1  FIFO holds 0 bytes.
- `busy`  out  1  frame in flight or FIFO non-empty.
- `level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky: a write arrived while `full`.
- `tx`  out  1  serial line, idle high.

## Operation
- Reset values: `tx`=1, `full`=0, `empty`=1, `busy`=0, `level`=0, `overflow`=0, FSM=IDLE, pointers/counters 0. Asynchronous assertion, synchronous-to-clk effect on deassertion edge only.
- FIFO: read/write pointers of $clog2(FIFO_DEPTH)+1 bits, wrap naturally modulo 2·DEPTH; `full`/`empty`/`level` derived from pointers, all registered-state based.
- Write accepted at posedge when `wr_en && !full`. `wr_en && full` → byte dropped, `overflow` set. Decision uses `full` before this edge, even if a pop happens the same edge.
- Simultaneous accepted write and pop: `level` unchanged, both pointers advance.
- `clr_overflow` and an overflowing write in the same cycle → `overflow` stays 1 (set wins).
- FSM states IDLE, START, DATA, STOP:
  - IDLE: `tx`=1. If `!empty`: pop head into shift register, go START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: `tx`=shift[0], LSB first; each CLKS_PER_BIT cycles shift right, index+1; after index 7 → STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. On its last cycle: if `!empty` pop and go START (back-to-back), else IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1, reset to 0 on every state/bit transition.
- `busy` = (state≠IDLE) || !empty.

## Timing
- Write at edge N into idle, empty block → FSM pops at edge N+1; `tx` falls after edge N+1 (1-cycle latency).
- Frame length exactly 10·CLKS_PER_BIT cycles; back-to-back frames have zero idle gap.
- `tx` is a registered output (no glitches).
- A byte popped into the shift register frees its FIFO slot immediately; `full` deasserts the cycle after the pop.
- Reset mid-frame: `tx` returns to 1 asynchronously, FIFO contents discarded, partial frame abandoned.

## Structure
- `riscv_pkg`: `UART_CLKS_PER_BIT` default constant and the `uart_state_t` enum (IDLE/START/DATA/STOP), shared with any future receiver.
- One sub-module natural: `sync_fifo` (parameterised width/depth, push/pop, full/empty/level) instantiated with width 8; FSM, baud counter and shift register live in `uart_tx_fifo`.
- DataMemory instantiates this block in place of its inline transmitter; its `CLKS_PER_BIT` passes through.

## Test plan
- CLKS_PER_BIT=4: write 0x55 once → `tx` low 1 cycle after write edge, then bits 1,0,1,0,1,0,1,0 each 4 cycles, stop high 4 cycles; `busy` falls exactly 40 cycles after `tx` fell.
- Write 0x41,0x42,0x43 on consecutive cycles → three frames back-to-back, 120 cycles total, no high gap between stop and next start; decoded bytes in order.
- Write 9 bytes on consecutive cycles with DEPTH=8 and CLKS_PER_BIT=4 → first pops after cycle 1, so all 9 accepted, `overflow`=0; repeat with 10 → 10th dropped, `overflow`=1, `level`=8 after it; `clr_overflow` → 0.
- With FIFO full, `wr_en` on the same edge a pop occurs → write rejected, `level` becomes DEPTH−1, `overflow`=1.
- Assert `rst_n` low mid-DATA bit 3 → `tx`=1, `level`=0, `busy`=0 immediately; after release, a new write 0xA5 transmits correctly.
- Pointer wrap: stream 20 bytes at a rate that keeps `level` ≤ 3 → all 20 received in order, `empty`=1 at end.
